// File: rtl/lfsr_pair_generator.sv
// ---------------------------------------------------------------------------
// lfsr_pair_generator
//
// Pseudo-random operand-pair source for the radix-4 multiplier test path.
// A Galois LFSR of 2*OP_WIDTH bits is split into two operands: x is the
// upper half and y is the lower half. A run is requested with start and
// emits num_pairs pairs, or runs forever when num_pairs is 0. The pairs
// leave through a valid/ready handshake, so the consumer can stall the
// stream.
//
// Ports:
//   clk                 rising-edge clock
//   reset_to_generator  synchronous active-low reset, highest priority
//   start               one-cycle run request (accepted in IDLE/DONE)
//   num_pairs           pairs per run, 0 = free-run (sampled on start)
//   seed_load           load seed_in into the LFSR (accepted in IDLE/DONE)
//   seed_in             seed value; zero is replaced by SEED
//   out_ready           downstream accepts the presented pair
//   out_valid           x/y hold a valid pair
//   x, y                upper/lower halves of the LFSR state
//   pair_idx            0-based index of the presented pair
//   busy                a run is in progress
//   done                last run finished; cleared by the next start
// ---------------------------------------------------------------------------
module lfsr_pair_generator #(
   parameter int                    OP_WIDTH   = 8,
   parameter int                    LFSR_WIDTH = 2 * OP_WIDTH,
   parameter logic [LFSR_WIDTH-1:0] TAPS       = 16'h002D,
   parameter logic [LFSR_WIDTH-1:0] SEED       = 16'h8000,
   parameter int                    CNT_WIDTH  = 6
) (
   input  logic                  clk,
   input  logic                  reset_to_generator,
   input  logic                  start,
   input  logic [CNT_WIDTH-1:0]  num_pairs,
   input  logic                  seed_load,
   input  logic [LFSR_WIDTH-1:0] seed_in,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [OP_WIDTH-1:0]   x,
   output logic [OP_WIDTH-1:0]   y,
   output logic [CNT_WIDTH-1:0]  pair_idx,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // One Galois step: shift left, fold the outgoing MSB back through TAPS.
   function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] v);
      logic [LFSR_WIDTH-1:0] fb;
      fb = v[LFSR_WIDTH-1] ? TAPS : {LFSR_WIDTH{1'b0}};
      return {v[LFSR_WIDTH-2:0], 1'b0} ^ fb;
   endfunction

   // A zero seed would lock the LFSR at zero, so it is replaced by SEED.
   function automatic logic [LFSR_WIDTH-1:0] seed_fix(input logic [LFSR_WIDTH-1:0] v);
      return (v == {LFSR_WIDTH{1'b0}}) ? SEED : v;
   endfunction

   state_t                state_r;
   logic [LFSR_WIDTH-1:0] lfsr_r;
   logic [CNT_WIDTH-1:0]  count_r;
   logic [CNT_WIDTH-1:0]  pair_idx_r;
   logic                  out_valid_r;
   logic                  busy_r;
   logic                  done_r;

   logic                  handshake_s;
   logic                  last_pair_s;

   assign handshake_s = out_valid_r & out_ready;
   // A count of zero means free-run, so it never produces a last pair.
   assign last_pair_s = (count_r != {CNT_WIDTH{1'b0}}) &&
                        (pair_idx_r == (count_r - CNT_WIDTH'(1)));

   // Control FSM with LFSR, counters and all status outputs registered.
   always_ff @(posedge clk) begin
      if (!reset_to_generator) begin
         state_r     <= ST_IDLE;
         lfsr_r      <= SEED;
         count_r     <= {CNT_WIDTH{1'b0}};
         pair_idx_r  <= {CNT_WIDTH{1'b0}};
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               // Seed first, so a same-cycle start presents the new seed.
               if (seed_load) begin
                  lfsr_r <= seed_fix(seed_in);
               end
               if (start) begin
                  state_r     <= ST_RUN;
                  count_r     <= num_pairs;
                  pair_idx_r  <= {CNT_WIDTH{1'b0}};
                  out_valid_r <= 1'b1;
                  busy_r      <= 1'b1;
                  done_r      <= 1'b0;
               end
            end
            ST_RUN: begin
               // Nothing moves while the consumer stalls.
               if (handshake_s) begin
                  lfsr_r     <= lfsr_step(lfsr_r);
                  pair_idx_r <= pair_idx_r + CNT_WIDTH'(1);
                  if (last_pair_s) begin
                     state_r     <= ST_DONE;
                     out_valid_r <= 1'b0;
                     busy_r      <= 1'b0;
                     done_r      <= 1'b1;
                  end
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               out_valid_r <= 1'b0;
               busy_r      <= 1'b0;
               done_r      <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid = out_valid_r;
   assign x         = lfsr_r[LFSR_WIDTH-1 -: OP_WIDTH];
   assign y         = lfsr_r[OP_WIDTH-1:0];
   assign pair_idx  = pair_idx_r;
   assign busy      = busy_r;
   assign done      = done_r;

endmodule

// File: tb/tb_lfsr_pair_generator.sv
// ---------------------------------------------------------------------------
// tb_lfsr_pair_generator
//
// Self-checking bench for lfsr_pair_generator with default parameters.
// The reference model treats the LFSR state as a polynomial over GF(2):
// each accepted pair multiplies it by 2 and reduces by the feedback
// polynomial whenever it overflows 16 bits.
// ---------------------------------------------------------------------------
module tb_lfsr_pair_generator;

   localparam logic [15:0] SEED_C = 16'h8000;
   localparam int          POLY_C = 32'h0001_002D;   // x^16+x^5+x^3+x^2+1

   logic        clk = 1'b0;
   logic        reset_to_generator;
   logic        start;
   logic [5:0]  num_pairs;
   logic        seed_load;
   logic [15:0] seed_in;
   logic        out_ready;
   logic        out_valid;
   logic [7:0]  x;
   logic [7:0]  y;
   logic [5:0]  pair_idx;
   logic        busy;
   logic        done;

   int          checks = 0;
   int          errors = 0;

   logic [15:0] m_lfsr;
   logic [5:0]  m_idx;

   lfsr_pair_generator dut (
      .clk                (clk),
      .reset_to_generator (reset_to_generator),
      .start              (start),
      .num_pairs          (num_pairs),
      .seed_load          (seed_load),
      .seed_in            (seed_in),
      .out_ready          (out_ready),
      .out_valid          (out_valid),
      .x                  (x),
      .y                  (y),
      .pair_idx           (pair_idx),
      .busy               (busy),
      .done               (done)
   );

   always #5 clk = ~clk;

   // Multiply by x modulo the feedback polynomial.
   function automatic logic [15:0] model_next(input logic [15:0] v);
      int t;
      t = int'(v) * 2;
      if (t >= 65536) t = t ^ POLY_C;
      return t[15:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset_to_generator = 1'b0;
      tick();
      reset_to_generator = 1'b1;
      m_lfsr = SEED_C;
      m_idx  = 6'd0;
   endtask

   task automatic do_start(input logic [5:0] n, input logic sl, input logic [15:0] s);
      num_pairs = n;
      seed_load = sl;
      seed_in   = s;
      start     = 1'b1;
      tick();
      start     = 1'b0;
      seed_load = 1'b0;
      if (sl) m_lfsr = (s == 16'h0000) ? SEED_C : s;
      m_idx = 6'd0;
   endtask

   task automatic test_reset();
      start = 1'b0; seed_load = 1'b0; seed_in = 16'h0000;
      num_pairs = 6'd0; out_ready = 1'b0;
      reset_to_generator = 1'b0;
      tick();
      tick();
      reset_to_generator = 1'b1;
      m_lfsr = SEED_C;
      m_idx  = 6'd0;
      checks++;
      if ({out_valid, busy, done} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags got v/b/d=%b%b%b exp 000", out_valid, busy, done);
      end
      checks++;
      if ({x, y, pair_idx} !== {16'h8000, 6'd0}) begin
         errors++;
         $display("FAIL reset_state got x=%h y=%h idx=%0d exp 80 00 0", x, y, pair_idx);
      end
   endtask

   task automatic test_basic();
      logic [15:0] exp_tab [3];
      exp_tab[0] = 16'h8000; exp_tab[1] = 16'h002D; exp_tab[2] = 16'h005A;
      out_ready = 1'b1;
      do_start(6'd3, 1'b0, 16'h0000);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (out_valid !== 1'b1 || {x, y} !== exp_tab[i] || pair_idx !== 6'(i)) begin
            errors++;
            $display("FAIL basic_pair%0d got v=%b xy=%h idx=%0d exp v=1 xy=%h idx=%0d",
                     i, out_valid, {x, y}, pair_idx, exp_tab[i], i);
         end
         m_lfsr = model_next(m_lfsr);
         tick();
      end
      checks++;
      if ({out_valid, busy, done} !== 3'b001) begin
         errors++;
         $display("FAIL basic_end got v/b/d=%b%b%b exp 001", out_valid, busy, done);
      end
   endtask

   task automatic test_stall();
      int hs = 0;
      int cyc = 0;
      logic first = 1'b1;
      apply_reset();
      do_start(6'd3, 1'b0, 16'h0000);
      while (hs < 3 && cyc < 200) begin
         checks++;
         if (out_valid !== 1'b1 || {x, y} !== m_lfsr || pair_idx !== m_idx) begin
            errors++;
            $display("FAIL stall_pair got v=%b xy=%h idx=%0d exp v=1 xy=%h idx=%0d",
                     out_valid, {x, y}, pair_idx, m_lfsr, m_idx);
         end
         // Force a stall on the first pair, random afterwards.
         out_ready = first ? 1'b0 : 1'($urandom_range(0, 1));
         first = 1'b0;
         tick();
         cyc++;
         if (out_ready) begin
            m_lfsr = model_next(m_lfsr);
            m_idx++;
            hs++;
         end
      end
      checks++;
      if (hs != 3) begin
         errors++;
         $display("FAIL stall_timeout got %0d handshakes exp 3", hs);
      end
      checks++;
      if ({out_valid, done} !== 2'b01) begin
         errors++;
         $display("FAIL stall_end got v/d=%b%b exp 01", out_valid, done);
      end
   endtask

   task automatic test_long_and_continue();
      int hs = 0;
      int cyc = 0;
      logic [5:0] last_idx = 6'd0;
      apply_reset();
      do_start(6'd32, 1'b0, 16'h0000);
      while (hs < 32 && cyc < 500) begin
         checks++;
         if (out_valid !== 1'b1 || {x, y} !== m_lfsr || pair_idx !== m_idx) begin
            errors++;
            $display("FAIL long_pair got v=%b xy=%h idx=%0d exp v=1 xy=%h idx=%0d",
                     out_valid, {x, y}, pair_idx, m_lfsr, m_idx);
         end
         out_ready = ($urandom_range(0, 3) != 0);
         last_idx = pair_idx;
         tick();
         cyc++;
         if (out_ready) begin
            m_lfsr = model_next(m_lfsr);
            m_idx++;
            hs++;
         end
      end
      checks++;
      if (hs != 32 || last_idx !== 6'd31 || done !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL long_end got hs=%0d last_idx=%0d done=%b v=%b exp 32 31 1 0",
                  hs, last_idx, done, out_valid);
      end
      out_ready = 1'b0;
      do_start(6'd1, 1'b0, 16'h0000);
      checks++;
      if ({x, y} !== m_lfsr || {out_valid, busy, done} !== 3'b110) begin
         errors++;
         $display("FAIL continue_pair got xy=%h v/b/d=%b%b%b exp xy=%h 110",
                  {x, y}, out_valid, busy, done, m_lfsr);
      end
      out_ready = 1'b1;
      tick();
      m_lfsr = model_next(m_lfsr);
      checks++;
      if ({out_valid, done} !== 2'b01) begin
         errors++;
         $display("FAIL continue_end got v/d=%b%b exp 01", out_valid, done);
      end
   endtask

   task automatic test_seed();
      logic [15:0] seeds [4];
      seeds[0] = 16'h0000; seeds[1] = 16'h1234;
      seeds[2] = 16'($urandom); seeds[3] = 16'($urandom);
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         do_start(6'd2, 1'b1, seeds[k]);
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (out_valid !== 1'b1 || {x, y} !== m_lfsr || pair_idx !== m_idx) begin
               errors++;
               $display("FAIL seed%0d_pair%0d got xy=%h idx=%0d exp xy=%h idx=%0d",
                        k, i, {x, y}, pair_idx, m_lfsr, m_idx);
            end
            m_lfsr = model_next(m_lfsr);
            m_idx++;
            tick();
         end
      end
      // Seed load on its own in DONE, then a plain start.
      seed_in = 16'hBEEF; seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
      m_lfsr = 16'hBEEF;
      do_start(6'd1, 1'b0, 16'h0000);
      checks++;
      if ({x, y} !== 16'hBEEF) begin
         errors++;
         $display("FAIL seed_only got xy=%h exp beef", {x, y});
      end
      tick();
      m_lfsr = model_next(m_lfsr);
   endtask

   task automatic test_free_run();
      int hs = 0;
      int cyc = 0;
      logic wrapped = 1'b0;
      do_start(6'd0, 1'b0, 16'h0000);
      while (hs < 70 && cyc < 400) begin
         checks++;
         if (out_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 ||
             {x, y} !== m_lfsr || pair_idx !== m_idx) begin
            errors++;
            $display("FAIL free_pair got v/b/d=%b%b%b xy=%h idx=%0d exp 110 xy=%h idx=%0d",
                     out_valid, busy, done, {x, y}, pair_idx, m_lfsr, m_idx);
         end
         if (hs == 64 && m_idx == 6'd0) wrapped = 1'b1;
         out_ready = ($urandom_range(0, 3) != 0);
         start     = ($urandom_range(0, 7) == 0);
         seed_load = ($urandom_range(0, 7) == 0);
         seed_in   = 16'($urandom);
         num_pairs = 6'($urandom);
         tick();
         cyc++;
         if (out_ready) begin
            m_lfsr = model_next(m_lfsr);
            m_idx++;
            hs++;
         end
      end
      start = 1'b0; seed_load = 1'b0;
      checks++;
      if (hs != 70 || !wrapped) begin
         errors++;
         $display("FAIL free_timeout got hs=%0d wrapped=%b exp 70 1", hs, wrapped);
      end
   endtask

   task automatic test_reset_mid_run();
      out_ready = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b1 || {x, y} !== m_lfsr) begin
         errors++;
         $display("FAIL midrst_pre got v=%b xy=%h exp v=1 xy=%h", out_valid, {x, y}, m_lfsr);
      end
      reset_to_generator = 1'b0;
      start = 1'b1; seed_load = 1'b1; seed_in = 16'h1111; num_pairs = 6'd5;
      tick();
      start = 1'b0; seed_load = 1'b0;
      checks++;
      if ({out_valid, busy, done} !== 3'b000 || {x, y} !== SEED_C || pair_idx !== 6'd0) begin
         errors++;
         $display("FAIL midrst got v/b/d=%b%b%b xy=%h idx=%0d exp 000 8000 0",
                  out_valid, busy, done, {x, y}, pair_idx);
      end
      reset_to_generator = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL midrst_idle got v/b=%b%b exp 00", out_valid, busy);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_long_and_continue();
      test_seed();
      test_free_run();
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lfsr_pair_generator.md
Name: lfsr_pair_generator

Overview:
- Parametrised pseudo-random operand-pair source for the radix-4 multiplier test path.
- A Galois LFSR of 2*OP_WIDTH bits is split into operands x (upper half) and y (lower half).
- Adds start/done control, a run-time pair count, seed loading and a valid/ready output handshake, so a downstream multiplier or checker can stall the stream.
- Default parameters reproduce the team's 16-bit generator: polynomial x^16+x^5+x^3+x^2+1, seed 0x8000, 32 pairs.

Parameters:
- OP_WIDTH, 8: width of each operand x and y.
- LFSR_WIDTH, 2*OP_WIDTH: LFSR state width; must equal 2*OP_WIDTH.
- TAPS, 16'h002D: Galois feedback mask; bit i set means bit i receives the MSB by XOR (bit 0 receives the MSB directly).
- SEED, 16'h8000: LFSR value after reset, and the substitute for any zero seed.
- CNT_WIDTH, 6: width of num_pairs and pair_idx.

Ports:
- clk  in  1  rising-edge clock
- reset_to_generator  in  1  synchronous, active-low reset
- start  in  1  one-cycle request to begin a run; honoured in IDLE/DONE only
- num_pairs  in  CNT_WIDTH  pairs to emit; sampled when start is accepted; 0 = free-run
- seed_load  in  1  load seed_in into the LFSR; honoured in IDLE/DONE only
- seed_in  in  LFSR_WIDTH  seed value
- out_ready  in  1  downstream accepts the pair
- out_valid  out  1  x/y hold a valid pair
- x  out  OP_WIDTH  lfsr[LFSR_WIDTH-1 -: OP_WIDTH]
- y  out  OP_WIDTH  lfsr[OP_WIDTH-1:0]
- pair_idx  out  CNT_WIDTH  index of the pair currently presented (0-based)
- busy  out  1  state == RUN
- done  out  1  high in DONE; cleared on the next accepted start

Behaviour:
- Single clock domain. Reset is synchronous, active-low, and has priority over all other inputs.
- On reset, regardless of state or handshake:
  - lfsr = SEED; state = IDLE
  - out_valid = 0; done = 0; busy = 0; pair_idx = 0; latched count = 0
- LFSR step: next = {lfsr[LFSR_WIDTH-2:0],1'b0} ^ (lfsr[LFSR_WIDTH-1] ? TAPS : 0).
- The LFSR advances only on a handshake (out_valid && out_ready); it never advances while stalled.
- States:
  - IDLE: out_valid = 0.
    - seed_load: lfsr <= (seed_in == 0 ? SEED : seed_in).
    - start: latch num_pairs, pair_idx <= 0, go to RUN.
  - RUN: out_valid = 1, starting the cycle after start (start-to-first-valid latency 1 cycle). The first pair is the current LFSR value, unadvanced.
    - Handshake: lfsr steps, pair_idx += 1.
    - If count != 0 and pair_idx == count-1 at the handshake: go to DONE; out_valid drops next cycle.
    - Free-run (count == 0): never leaves RUN; pair_idx wraps modulo 2^CNT_WIDTH.
    - start and seed_load are ignored in RUN.
  - DONE: out_valid = 0, done = 1. The LFSR holds its post-run value, so the next run continues the sequence.
    - seed_load behaves as in IDLE.
    - start: same as from IDLE, and clears done.
- seed_load and start in the same cycle: the seed loads and the run starts; the first pair is the loaded seed (zero substituted by SEED).
- Stall rule: while out_valid && !out_ready, x, y and pair_idx are held stable.
- Zero-lockup protection: all-zero LFSR state is unreachable, because a zero seed is replaced and the polynomial has a nonzero TAPS[0].

Test Plan:
- Reset, then start with num_pairs=3, out_ready=1 -> pairs (x,y) = (0x80,0x00), (0x00,0x2D), (0x00,0x5A); out_valid high for exactly 3 cycles; done=1 afterwards.
- Same run with out_ready toggling 1,0,0,1,... -> x/y/pair_idx frozen during the 0 cycles; identical three-pair sequence; total cycles = 3 + stall cycles.
- num_pairs=32, default parameters -> 32 handshakes; final pair_idx=31; then start again with num_pairs=1 -> the single pair continues the sequence (33rd LFSR state), not the seed.
- seed_load with seed_in=0x0000 plus start, num_pairs=2 -> first pair (0x80,0x00), second (0x00,0x2D); seed_in=0x1234 -> first pair (0x12,0x34), second (0x24,0x68).
- Free-run (num_pairs=0) for 70 handshakes -> pair_idx wraps 63->0; busy stays 1; done stays 0; start/seed_load pulses mid-run have no effect.
- reset_to_generator=0 mid-run while out_valid && !out_ready -> next cycle out_valid=0, state IDLE, lfsr=0x8000, pair_idx=0, done=0.
